fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the single-entry stall-on-miss IF stage.
- Owns the fetch PC, issues requests on the instruction bus, and buffers up to DEPTH fetched {pc, instr} pairs in a FIFO.
- Decouples ibus latency from decode; decode drains the FIFO with a valid/ready handshake.
- Supports redirect (branch/jump resolved in MEM) with a flush and correct discard of an in-flight response.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PC_RESET, 64'h0000_0000_8000_0000, fetch PC after reset.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- ireq  out  ibus_req_t  instruction-bus request (valid, addr).
- iresp  in  ibus_resp_t  instruction-bus response (data_ok, data[31:0]).
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  64  new fetch PC; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  FIFO head is valid.
- out_pc  out  64  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- out_ready  in  1  decode accepts the head this cycle.
- count  out  CNT_W  current FIFO occupancy.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, fpc=PC_RESET, count=0, head=tail=0.
  - out_valid=0, ireq.valid=0.
  - A data_ok arriving while state=IDLE is ignored.
- FSM states: IDLE, REQ, DRAIN.
  - ireq.valid = (state==REQ || state==DRAIN).
  - ireq.addr = fpc in REQ; in DRAIN it is the held address of the abandoned request (drain_addr).
  - While ireq.valid=1, ireq.addr is stable until data_ok.
- IDLE:
  - redirect_valid sets fpc=redirect_pc, flushes, stays IDLE.
  - Otherwise, if count<DEPTH, go to REQ next cycle.
- REQ, data_ok=1 and no redirect:
  - Push {fpc, iresp.data} at tail; fpc+=4.
  - Stay REQ if count_next<DEPTH, otherwise go to IDLE.
  - count_next = count + 1 − pop.
- REQ, redirect_valid=1:
  - Flush; fpc=redirect_pc.
  - If data_ok=1 in the same cycle, drop the response and go to REQ at the new fpc.
  - Otherwise latch drain_addr=old fpc and go to DRAIN.
- DRAIN:
  - Hold the request until data_ok, drop that response, then go to REQ.
  - Further redirects in DRAIN only update fpc.
- Flush: count=0, head=tail=0 at the edge; out_valid=0 next cycle.
- Redirect has priority over push and pop in the same cycle.
- Pop: when out_valid && out_ready && !redirect_valid, head advances (wraps mod DEPTH) and count decrements.
- Simultaneous push and pop: count unchanged; both pointers advance.
- No overflow: a request is issued only when count<DEPTH, and only one request is outstanding. Space is therefore reserved at issue, since pops only free entries.
- Underflow impossible: pop requires out_valid.
- Outputs:
  - out_valid = (count!=0).
  - out_pc and out_instr are read from the head entry (registered storage, no combinational path from iresp).
  - Latency is data_ok to out_valid = 1 cycle.
- Throughput: one instruction per cycle when the bus returns data_ok every cycle and decode pops every cycle.
- fpc wraps modulo 2^64.

Test Plan:
- Reset then release, zero-wait bus, out_ready=1 → ireq.addr sequence 0x80000000, 0x80000004, …. out_valid rises one cycle after the first data_ok, with out_pc=0x80000000 and out_instr equal to the bus data.
- out_ready=0, DEPTH=4 → exactly 4 responses accepted, count=4. ireq.valid drops to 0 (IDLE), with no fifth request issued while full.
- Queue full, out_ready pulses for one cycle → count goes 4→3, then one new request is issued at the next sequential PC and count returns to 4.
- Request at 0x80000010 pending with data_ok delayed 3 cycles; redirect_valid to 0x80000100 → state DRAIN, ireq.addr held at 0x80000010 until data_ok. That response is dropped; the next request is at 0x80000100 and out_pc after the flush is 0x80000100.
- redirect_valid and data_ok in the same cycle, plus out_ready=1 with count=2 → response dropped, count=0 next cycle, next ireq.addr=redirect_pc.
- reset asserted mid-request with data_ok arriving one cycle after reset releases → response ignored, count=0, first new request at 0x80000000.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Bus types and the handshake interface between the fetch queue,
// the instruction bus and decode.
package fetch_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

interface fetch_queue_if;
    import fetch_queue_pkg::*;

    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    // Fetch-queue side
    modport master (
        output ireq, out_valid, out_pc, out_instr,
        input  iresp, redirect_valid, redirect_pc, out_ready
    );

    // Bus / pipeline side
    modport slave (
        input  ireq, out_valid, out_pc, out_instr,
        output iresp, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one ibus
// request outstanding and buffers fetched {pc, instr} pairs in a small FIFO
// that decode drains with valid/ready. A redirect flushes the FIFO; a
// request that was already on the bus is allowed to complete and its
// response is thrown away (DRAIN).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
    parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    fetch_queue_if.master    bus,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [63:0]        fpc_q, fpc_d;
    logic [63:0]        drain_addr_q, drain_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;

    logic [63:0]        entry_pc_q    [DEPTH];
    logic [31:0]        entry_instr_q [DEPTH];

    logic               out_valid_w;
    logic               pop;
    logic               push;
    logic               flush;
    logic [63:0]        rpc_aligned;
    logic [CNT_W-1:0]   count_push;
    ibus_req_t          ireq_w;

    assign out_valid_w = (count_q != '0);
    // Redirect wins over a pop in the same cycle.
    assign pop         = out_valid_w && bus.out_ready && !bus.redirect_valid;
    assign rpc_aligned = bus.redirect_pc & ~64'h3;
    // Occupancy after a push in a cycle that may also pop.
    assign count_push  = count_q + CNT_W'(1) - CNT_W'(pop);

    // Next-state, fetch PC and FIFO pointer computation.
    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        drain_addr_d = drain_addr_q;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        push         = 1'b0;
        flush        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.redirect_valid) begin
                    fpc_d = rpc_aligned;
                    flush = 1'b1;
                end else if (count_q < CNT_W'(DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    fpc_d = rpc_aligned;
                    if (!bus.iresp.data_ok) begin
                        // The old request stays on the bus until it answers.
                        drain_addr_d = fpc_q;
                        state_d      = DRAIN;
                    end
                end else if (bus.iresp.data_ok) begin
                    push  = 1'b1;
                    fpc_d = fpc_q + 64'd4;
                    // Only ask again if the slot for the answer is guaranteed.
                    state_d = (count_push < CNT_W'(DEPTH)) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (bus.redirect_valid) begin
                    fpc_d = rpc_aligned;
                    flush = 1'b1;
                end
                if (bus.iresp.data_ok) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            fpc_q        <= PC_RESET;
            drain_addr_q <= '0;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_pc_q[tail_q]    <= fpc_q;
            entry_instr_q[tail_q] <= bus.iresp.data;
        end
    end

    // Bus request and decode-side outputs, all taken from registered state.
    always_comb begin
        ireq_w.valid = (state_q == REQ) || (state_q == DRAIN);
        ireq_w.addr  = (state_q == DRAIN) ? drain_addr_q : fpc_q;
    end

    assign bus.ireq      = ireq_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_pc    = entry_pc_q[head_q];
    assign bus.out_instr = entry_instr_q[head_q];
    assign count         = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH    = 4;
    localparam int          CNT_W    = $clog2(DEPTH + 1);
    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] count;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .PC_RESET (PC_RESET)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];      // buffered instructions, oldest first
    bit          m_out;      // a request is on the bus
    bit          m_disc;     // its answer belongs to a flushed stream
    logic [63:0] m_addr;     // address on the bus
    logic [63:0] m_fpc;      // next sequential fetch PC

    task automatic model_step(input logic rst_n, input logic dok, input logic [31:0] data,
                              input logic rdy, input logic rv, input logic [63:0] rpc);
        logic [63:0] tgt;
        bit          do_pop;
        bit          start;
        tgt    = rpc & ~64'h3;
        do_pop = (mq.size() != 0) && rdy && !rv;
        if (!rst_n) begin
            mq.delete();
            m_fpc  = PC_RESET;
            m_out  = 1'b0;
            m_disc = 1'b0;
            m_addr = '0;
        end else if (!m_out) begin
            if (rv) begin
                m_fpc = tgt;
                mq.delete();
            end else begin
                start = (mq.size() < DEPTH);
                if (do_pop) mq.delete(0);
                if (start) begin
                    m_out  = 1'b1;
                    m_disc = 1'b0;
                    m_addr = m_fpc;
                end
            end
        end else if (m_disc) begin
            if (rv) begin
                m_fpc = tgt;
                mq.delete();
            end
            if (dok) begin
                m_disc = 1'b0;
                m_addr = m_fpc;
            end
        end else begin
            if (rv) begin
                mq.delete();
                m_fpc = tgt;
                if (dok) m_addr = m_fpc;
                else     m_disc = 1'b1;
            end else begin
                if (do_pop) mq.delete(0);
                if (dok) begin
                    mq.push_back('{pc: m_addr, instr: data});
                    m_fpc = m_addr + 64'd4;
                    if (mq.size() < DEPTH) m_addr = m_fpc;
                    else                   m_out  = 1'b0;
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Apply one cycle of inputs, advance the model, sample 1ns after the edge.
    task automatic drive(input logic rst_n, input logic dok, input logic [31:0] data,
                         input logic rdy, input logic rv, input logic [63:0] rpc);
        reset              = rst_n;
        bus.iresp          = '{data_ok: dok, data: data};
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        model_step(rst_n, dok, data, rdy, rv, rpc);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic compare_model(input int cyc);
        chk($sformatf("rnd%0d ireq_valid", cyc), 64'(bus.ireq.valid), 64'(m_out));
        if (m_out) chk($sformatf("rnd%0d ireq_addr", cyc), bus.ireq.addr, m_addr);
        chk($sformatf("rnd%0d out_valid", cyc), 64'(bus.out_valid), 64'(mq.size() != 0));
        chk($sformatf("rnd%0d count", cyc), 64'(count), 64'(mq.size()));
        if (mq.size() != 0) begin
            chk($sformatf("rnd%0d out_pc", cyc), bus.out_pc, mq[0].pc);
            chk($sformatf("rnd%0d out_instr", cyc), 64'(bus.out_instr), 64'(mq[0].instr));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        dok;
        logic [31:0] data;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        ev;
        logic [63:0] ea;
        logic        eov;
        logic [63:0] epc;
        logic [31:0] ei;
        int          ecnt;
    } vec_t;

    vec_t vt[8];

    initial begin
        reset              = 1'b0;
        bus.iresp          = '0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        //        dok data          rdy rv rpc            ev ea             eov epc            ei            cnt
        vt[0] = '{1'b1, 32'h0,        1'b1, 1'b0, 64'h0,        1'b1, 64'h8000_0000, 1'b0, 64'h0,         32'h0,        0};
        vt[1] = '{1'b1, 32'h1111_0000, 1'b1, 1'b0, 64'h0,        1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000, 32'h1111_0000, 1};
        vt[2] = '{1'b1, 32'h1111_0001, 1'b1, 1'b0, 64'h0,        1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004, 32'h1111_0001, 1};
        vt[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 64'h0,        1'b1, 64'h8000_0008, 1'b0, 64'h0,         32'h0,        0};
        vt[4] = '{1'b1, 32'h1111_0002, 1'b0, 1'b0, 64'h0,        1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008, 32'h1111_0002, 1};
        vt[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 64'h8000_0203, 1'b1, 64'h8000_000C, 1'b0, 64'h0,         32'h0,        0};
        vt[6] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 64'h0,        1'b1, 64'h8000_0200, 1'b0, 64'h0,         32'h0,        0};
        vt[7] = '{1'b1, 32'h2222_0000, 1'b0, 1'b0, 64'h0,        1'b1, 64'h8000_0204, 1'b1, 64'h8000_0200, 32'h2222_0000, 1};

        // Reset state
        reset_dut();
        chk("reset ireq_valid", 64'(bus.ireq.valid), 64'h0);
        chk("reset out_valid", 64'(bus.out_valid), 64'h0);
        chk("reset count", 64'(count), 64'h0);

        // Table: zero-wait fetch, pops, redirect with drain
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vt[i].dok, vt[i].data, vt[i].rdy, vt[i].rv, vt[i].rpc);
            chk($sformatf("vec%0d ireq_valid", i), 64'(bus.ireq.valid), 64'(vt[i].ev));
            if (vt[i].ev) chk($sformatf("vec%0d ireq_addr", i), bus.ireq.addr, vt[i].ea);
            chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(vt[i].eov));
            chk($sformatf("vec%0d count", i), 64'(count), 64'(vt[i].ecnt));
            if (vt[i].eov) begin
                chk($sformatf("vec%0d out_pc", i), bus.out_pc, vt[i].epc);
                chk($sformatf("vec%0d out_instr", i), 64'(bus.out_instr), 64'(vt[i].ei));
            end
            $display("vec %0d addr=%h count=%0d out_pc=%h", i, bus.ireq.addr, count, bus.out_pc);
        end

        // Fill with decode stalled: four responses, then no further request
        reset_dut();
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 64'h0);
        chk("full count", 64'(count), 64'd4);
        chk("full ireq_valid", 64'(bus.ireq.valid), 64'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'hA100_0000, 1'b0, 1'b0, 64'h0);
            chk("full hold ireq_valid", 64'(bus.ireq.valid), 64'h0);
        end
        chk("full hold count", 64'(count), 64'd4);
        chk("full head pc", bus.out_pc, 64'h8000_0000);
        chk("full head instr", 64'(bus.out_instr), 64'hA000_0001);
        $display("fill done count=%0d", count);

        // One-cycle pop while full, then one refill request
        drive(1'b1, 1'b1, 32'hB000_0000, 1'b1, 1'b0, 64'h0);
        chk("pop1 count", 64'(count), 64'd3);
        chk("pop1 ireq_valid", 64'(bus.ireq.valid), 64'h0);
        chk("pop1 head pc", bus.out_pc, 64'h8000_0004);
        drive(1'b1, 1'b1, 32'hB000_0001, 1'b0, 1'b0, 64'h0);
        chk("refill ireq_valid", 64'(bus.ireq.valid), 64'h1);
        chk("refill ireq_addr", bus.ireq.addr, 64'h8000_0010);
        chk("refill count", 64'(count), 64'd3);
        drive(1'b1, 1'b1, 32'hB000_0002, 1'b0, 1'b0, 64'h0);
        chk("refilled count", 64'(count), 64'd4);
        chk("refilled ireq_valid", 64'(bus.ireq.valid), 64'h0);
        $display("refill done count=%0d", count);

        // Redirect while a request is pending: drain then restart
        reset_dut();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 32'hC000_0000 + 32'(k), 1'b1, 1'b0, 64'h0);
        chk("pend addr", bus.ireq.addr, 64'h8000_0010);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 64'h8000_0100);
        chk("drain ireq_valid", 64'(bus.ireq.valid), 64'h1);
        chk("drain addr", bus.ireq.addr, 64'h8000_0010);
        chk("drain count", 64'(count), 64'h0);
        chk("drain out_valid", 64'(bus.out_valid), 64'h0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
            chk("drain hold addr", bus.ireq.addr, 64'h8000_0010);
        end
        drive(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 64'h0);
        chk("after drain addr", bus.ireq.addr, 64'h8000_0100);
        chk("after drain count", 64'(count), 64'h0);
        drive(1'b1, 1'b1, 32'hC100_0000, 1'b0, 1'b0, 64'h0);
        chk("post flush out_valid", 64'(bus.out_valid), 64'h1);
        chk("post flush out_pc", bus.out_pc, 64'h8000_0100);
        chk("post flush out_instr", 64'(bus.out_instr), 64'hC100_0000);
        $display("drain done out_pc=%h", bus.out_pc);

        // Redirect and data_ok together with two entries queued and decode ready
        reset_dut();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        for (int k = 0; k < 2; k++) drive(1'b1, 1'b1, 32'hD000_0000 + 32'(k), 1'b0, 1'b0, 64'h0);
        chk("pre count", 64'(count), 64'd2);
        drive(1'b1, 1'b1, 32'hDEAD_0000, 1'b1, 1'b1, 64'h8000_0300);
        chk("same-cycle count", 64'(count), 64'h0);
        chk("same-cycle out_valid", 64'(bus.out_valid), 64'h0);
        chk("same-cycle addr", bus.ireq.addr, 64'h8000_0300);
        drive(1'b1, 1'b1, 32'hD100_0000, 1'b0, 1'b0, 64'h0);
        chk("same-cycle out_pc", bus.out_pc, 64'h8000_0300);
        chk("same-cycle out_instr", 64'(bus.out_instr), 64'hD100_0000);
        $display("same-cycle redirect done count=%0d", count);

        // Reset during a pending request; late data_ok is ignored
        reset_dut();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        chk("midreset ireq_valid", 64'(bus.ireq.valid), 64'h0);
        chk("midreset count", 64'(count), 64'h0);
        drive(1'b1, 1'b1, 32'hE000_0001, 1'b0, 1'b0, 64'h0);
        chk("ignored count", 64'(count), 64'h0);
        chk("ignored out_valid", 64'(bus.out_valid), 64'h0);
        chk("restart addr", bus.ireq.addr, 64'h8000_0000);
        drive(1'b1, 1'b1, 32'hE000_0002, 1'b0, 1'b0, 64'h0);
        chk("restart out_pc", bus.out_pc, 64'h8000_0000);
        chk("restart out_instr", 64'(bus.out_instr), 64'hE000_0002);
        $display("mid-request reset done count=%0d", count);

        // Randomized run against the reference model
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst;
            logic        r_dok;
            logic        r_rdy;
            logic        r_rv;
            logic [63:0] r_pc;
            r_rst = ($urandom_range(0, 199) != 0);
            r_dok = ($urandom_range(0, 99) < 60);
            r_rdy = ($urandom_range(0, 99) < 50);
            r_rv  = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0) r_pc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
            else                           r_pc = {$urandom, $urandom};
            drive(r_rst, r_dok, $urandom, r_rdy, r_rv, r_pc);
            compare_model(i);
        end
        $display("random run done cycles=3000");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
